// File: rtl/slc3_ctrl_if.sv
// Control bundle between the SLC-3 sequencer (master) and the datapath (slave):
// instruction/status inputs to the sequencer and every load, gate and select it drives.
interface slc3_ctrl_if;
    logic       Run;
    logic       Continue;
    logic [3:0] Opcode;
    logic       IR_5;
    logic       IR_11;
    logic       BEN;

    logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
    logic       GatePC, GateMDR, GateALU, GateMARMUX;
    logic [1:0] PCMUX;
    logic       DRMUX;
    logic       SR1MUX;
    logic       SR2MUX;
    logic       ADDR1MUX;
    logic [1:0] ADDR2MUX;
    logic [1:0] ALUK;
    logic       MIO_EN;
    logic       Mem_OE;
    logic       Mem_WE;

    modport master (
        input  Run, Continue, Opcode, IR_5, IR_11, BEN,
        output LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
        output GatePC, GateMDR, GateALU, GateMARMUX,
        output PCMUX, DRMUX, SR1MUX, SR2MUX, ADDR1MUX, ADDR2MUX, ALUK,
        output MIO_EN, Mem_OE, Mem_WE
    );

    modport slave (
        output Run, Continue, Opcode, IR_5, IR_11, BEN,
        input  LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
        input  GatePC, GateMDR, GateALU, GateMARMUX,
        input  PCMUX, DRMUX, SR1MUX, SR2MUX, ADDR1MUX, ADDR2MUX, ALUK,
        input  MIO_EN, Mem_OE, Mem_WE
    );
endinterface

// File: rtl/slc3_ctrl.sv
// SLC-3 control sequencer: fetch/decode/execute FSM for a reduced LC-3 ISA with
// fixed-latency memory strobes and a Run/Continue start/pause handshake.
module slc3_ctrl #(
    parameter int unsigned MEM_WAIT = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    slc3_ctrl_if.master bus
);

    typedef enum logic [4:0] {
        HALTED, F1, F2, F3, DECODE,
        S_ALU, S_NOT, S_BR, S_JMP, S_JSR1, S_JSR2,
        L1, L2, L3, W1, W2, W3, P1, P2, P3
    } state_t;

    localparam logic [2:0] CNT_LAST = 3'(MEM_WAIT - 1);

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       wait_done;

    logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
    logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
    logic [1:0] pcmux, addr2mux, aluk;
    logic       drmux, sr1mux, sr2mux, addr1mux;
    logic       mio_en, mem_oe, mem_we;

    assign wait_done = (cnt_q == CNT_LAST);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= HALTED;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = 3'd0;
        ld_mar      = 1'b0;
        ld_mdr      = 1'b0;
        ld_ir       = 1'b0;
        ld_ben      = 1'b0;
        ld_cc       = 1'b0;
        ld_reg      = 1'b0;
        ld_pc       = 1'b0;
        ld_led      = 1'b0;
        gate_pc     = 1'b0;
        gate_mdr    = 1'b0;
        gate_alu    = 1'b0;
        gate_marmux = 1'b0;
        pcmux       = 2'b00;
        drmux       = 1'b0;
        sr1mux      = 1'b0;
        sr2mux      = 1'b0;
        addr1mux    = 1'b0;
        addr2mux    = 2'b00;
        aluk        = 2'b00;
        mio_en      = 1'b0;
        mem_oe      = 1'b0;
        mem_we      = 1'b0;

        unique case (state_q)
            HALTED: if (bus.Run) state_d = F1;
            F1: begin
                gate_pc = 1'b1;
                ld_mar  = 1'b1;
                ld_pc   = 1'b1;
                state_d = F2;
            end
            F2, L2: begin
                mem_oe = 1'b1;
                mio_en = 1'b1;
                // Counter clears on exit so every wait state is entered with a zero count
                if (wait_done) begin
                    ld_mdr  = 1'b1;
                    state_d = (state_q == F2) ? F3 : L3;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            F3: begin
                gate_mdr = 1'b1;
                ld_ir    = 1'b1;
                state_d  = DECODE;
            end
            DECODE: begin
                ld_ben = 1'b1;
                unique case (bus.Opcode)
                    4'b0001, 4'b0101: state_d = S_ALU;
                    4'b1001:          state_d = S_NOT;
                    4'b0000:          state_d = S_BR;
                    4'b1100:          state_d = S_JMP;
                    4'b0100:          state_d = S_JSR1;
                    4'b0110:          state_d = L1;
                    4'b0111:          state_d = W1;
                    4'b1101:          state_d = P1;
                    default:          state_d = F1;
                endcase
            end
            S_ALU, S_NOT: begin
                gate_alu = 1'b1;
                ld_reg   = 1'b1;
                ld_cc    = 1'b1;
                sr1mux   = 1'b1;
                if (state_q == S_ALU) begin
                    sr2mux = bus.IR_5;
                    aluk   = {1'b0, bus.Opcode == 4'b0101};
                end else begin
                    aluk   = 2'b10;
                end
                state_d = F1;
            end
            S_BR: begin
                if (bus.BEN) begin
                    ld_pc    = 1'b1;
                    pcmux    = 2'b10;
                    addr2mux = 2'b10;
                end
                state_d = F1;
            end
            S_JMP: begin
                sr1mux   = 1'b1;
                aluk     = 2'b11;
                gate_alu = 1'b1;
                ld_pc    = 1'b1;
                pcmux    = 2'b01;
                state_d  = F1;
            end
            S_JSR1: begin
                gate_pc = 1'b1;
                drmux   = 1'b1;
                ld_reg  = 1'b1;
                state_d = S_JSR2;
            end
            S_JSR2: begin
                ld_pc = 1'b1;
                pcmux = 2'b10;
                if (bus.IR_11) begin
                    addr2mux = 2'b11;
                end else begin
                    addr1mux = 1'b1;
                    sr1mux   = 1'b1;
                end
                state_d = F1;
            end
            L1, W1: begin
                gate_marmux = 1'b1;
                ld_mar      = 1'b1;
                addr1mux    = 1'b1;
                sr1mux      = 1'b1;
                addr2mux    = 2'b01;
                state_d     = (state_q == L1) ? L2 : W2;
            end
            L3: begin
                gate_mdr = 1'b1;
                ld_reg   = 1'b1;
                ld_cc    = 1'b1;
                state_d  = F1;
            end
            W2: begin
                // Store data comes from IR[11:9] passed straight through the ALU
                aluk     = 2'b11;
                gate_alu = 1'b1;
                ld_mdr   = 1'b1;
                state_d  = W3;
            end
            W3: begin
                mem_we = 1'b1;
                if (wait_done) state_d = F1;
                else           cnt_d   = cnt_q + 3'd1;
            end
            P1: begin
                ld_led  = 1'b1;
                state_d = P2;
            end
            P2: if (bus.Continue)  state_d = P3;
            P3: if (!bus.Continue) state_d = F1;
            default: state_d = HALTED;
        endcase
    end

    assign bus.LD_MAR     = ld_mar;
    assign bus.LD_MDR     = ld_mdr;
    assign bus.LD_IR      = ld_ir;
    assign bus.LD_BEN     = ld_ben;
    assign bus.LD_CC      = ld_cc;
    assign bus.LD_REG     = ld_reg;
    assign bus.LD_PC      = ld_pc;
    assign bus.LD_LED     = ld_led;
    assign bus.GatePC     = gate_pc;
    assign bus.GateMDR    = gate_mdr;
    assign bus.GateALU    = gate_alu;
    assign bus.GateMARMUX = gate_marmux;
    assign bus.PCMUX      = pcmux;
    assign bus.DRMUX      = drmux;
    assign bus.SR1MUX     = sr1mux;
    assign bus.SR2MUX     = sr2mux;
    assign bus.ADDR1MUX   = addr1mux;
    assign bus.ADDR2MUX   = addr2mux;
    assign bus.ALUK       = aluk;
    assign bus.MIO_EN     = mio_en;
    assign bus.Mem_OE     = mem_oe;
    assign bus.Mem_WE     = mem_we;

endmodule
